mem_io_ctrl: RTL and testbench

Parametrised memory/IO controller between the CPU's MDR/MAR bus and the external async 1Mx16 SRAM and board I/O. It replaces fixed-timing strobes with a request/ready handshake, programmable SRAM wait states, byte-lane writes, and a configurable bank of memory-mapped hex-display registers plus a synchronised switch port. It sits between the CPU datapath/control unit and the top-level SRAM tristate buffer and HexDrivers.

---
 rtl/mem_io_pkg.sv | 30 +++
 rtl/sync_bus.sv | 33 +++
 rtl/mem_io_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mem_io_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// rtl/mem_io_pkg.sv - shared types and constants for the memory/IO controller
//
// Purpose : FSM state encoding, I/O offset map and inactive strobe levels
//           used by mem_io_ctrl.
// Ports   : none (package)
package mem_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_DONE
  } state_t;

  localparam int WAIT_W = 4;

  // I/O map relative to IO_BASE: hex registers first, switch port right after.
  localparam int HEX_OFS0 = 0;

  function automatic int sw_ofs(input int hex_words);
    return hex_words;
  endfunction

  // Inactive levels for the active-low SRAM strobes.
  localparam logic       STROBE_OFF = 1'b1;
  localparam logic [1:0] LANES_OFF  = 2'b11;

endpackage

// File: rtl/sync_bus.sv
// rtl/sync_bus.sv - two-flop synchroniser for an asynchronous bus
//
// Purpose : brings an asynchronous multi-bit input into the clock domain.
//           Intended for quasi-static inputs such as switches.
// Ports   : i_clk    - clock
//           i_resetn - synchronous active-low clear
//           i_d      - asynchronous input bus
//           o_q      - synchronised output bus
module sync_bus #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_resetn,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/mem_io_ctrl.sv
// rtl/mem_io_ctrl.sv - CPU to async SRAM and board I/O controller
//
// Purpose : request/ready front end for the CPU MAR/MDR bus. Drives a 1Mx16
//           async SRAM with programmable wait states and byte-lane writes,
//           and serves memory-mapped hex registers and a switch port.
// Ports   : Clk, Reset        - clock, synchronous active-low reset
//           cpu_req/we/be     - request, direction, byte enables {ub, lb}
//           cpu_addr/wdata    - access address and write data
//           cpu_rdata/ready   - read data and one-cycle completion pulse
//           busy              - high whenever the FSM is not idle
//           sram_*            - registered SRAM strobes, address and data
//           sram_dq_in        - data returned by the SRAM tristate
//           sw                - raw asynchronous switches
//           hex_out           - hex register contents, word k at [16k+15:16k]
module mem_io_ctrl
  import mem_io_pkg::*;
#(
  parameter int                CPU_AW      = 16,
  parameter int                SRAM_AW     = 20,
  parameter int                DW          = 16,
  parameter logic [CPU_AW-1:0] IO_BASE     = 16'hFFF0,
  parameter int                HEX_WORDS   = 2,
  parameter int                WAIT_STATES = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [1:0]           cpu_be,
  input  logic [CPU_AW-1:0]    cpu_addr,
  input  logic [DW-1:0]        cpu_wdata,
  output logic [DW-1:0]        cpu_rdata,
  output logic                 cpu_ready,
  output logic                 busy,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic                 sram_ub_n,
  output logic                 sram_lb_n,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic [DW-1:0]        sram_dq_out,
  output logic                 sram_dq_oe,
  input  logic [DW-1:0]        sram_dq_in,
  input  logic [DW-1:0]        sw,
  output logic [16*HEX_WORDS-1:0] hex_out
);

  localparam logic [WAIT_W-1:0] C_WAIT = WAIT_W'(WAIT_STATES);

  state_t            r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait, w_wait_nxt;
  logic [1:0]        r_be;
  logic [DW-1:0]     r_hex [HEX_WORDS];
  logic [DW-1:0]     r_rdata;
  logic              r_ready, r_busy;
  logic              r_ce_n, r_oe_n, r_we_n, r_ub_n, r_lb_n, r_dq_oe;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [DW-1:0]     r_dq_out;

  logic              w_accept, w_is_io, w_is_sw;
  logic [CPU_AW-1:0] w_ofs;
  logic [DW-1:0]     w_io_rdata, w_sw_sync;
  logic [1:0]        w_be_nxt;
  logic              w_ce_n, w_oe_n, w_we_n, w_ub_n, w_lb_n, w_dq_oe;

  sync_bus #(.W(DW)) u_sw_sync (
    .i_clk    (Clk),
    .i_resetn (Reset),
    .i_d      (sw),
    .o_q      (w_sw_sync)
  );

  assign w_accept = (r_state == ST_IDLE) && cpu_req;
  assign w_is_io  = (cpu_addr >= IO_BASE);
  assign w_ofs    = cpu_addr - IO_BASE;
  assign w_is_sw  = (w_ofs == CPU_AW'(sw_ofs(HEX_WORDS)));

  // I/O read data is selected at the accept edge; unmapped offsets read 0.
  always_comb begin
    w_io_rdata = '0;
    if (w_is_sw) w_io_rdata = w_sw_sync;
    for (int k = 0; k < HEX_WORDS; k++) begin
      if (w_ofs == CPU_AW'(HEX_OFS0 + k)) w_io_rdata = r_hex[k];
    end
  end

  // Next state. The wait counter is loaded at accept and counts down in RD
  // and WR_PULSE, so each lasts WAIT_STATES+1 cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    case (r_state)
      ST_IDLE: begin
        w_wait_nxt = C_WAIT;
        if (cpu_req) begin
          if (w_is_io)     w_state_nxt = ST_DONE;
          else if (cpu_we) w_state_nxt = ST_WR_SETUP;
          else             w_state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        if (r_wait == '0) w_state_nxt = ST_DONE;
        else              w_wait_nxt  = r_wait - 1'b1;
      end
      ST_WR_SETUP: w_state_nxt = ST_WR_PULSE;
      ST_WR_PULSE: begin
        if (r_wait == '0) w_state_nxt = ST_WR_HOLD;
        else              w_wait_nxt  = r_wait - 1'b1;
      end
      ST_WR_HOLD: w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state and then registered, so the
  // outputs line up with the state they belong to and stay glitch free.
  assign w_be_nxt = (r_state == ST_IDLE) ? cpu_be : r_be;

  always_comb begin
    w_ce_n  = STROBE_OFF;
    w_oe_n  = STROBE_OFF;
    w_we_n  = STROBE_OFF;
    {w_ub_n, w_lb_n} = LANES_OFF;
    w_dq_oe = 1'b0;
    case (w_state_nxt)
      ST_RD: begin
        w_ce_n = 1'b0;
        w_oe_n = 1'b0;
        {w_ub_n, w_lb_n} = 2'b00;
      end
      ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD: begin
        w_ce_n  = 1'b0;
        w_we_n  = (w_state_nxt == ST_WR_PULSE) ? 1'b0 : 1'b1;
        {w_ub_n, w_lb_n} = ~w_be_nxt;
        w_dq_oe = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state     <= ST_IDLE;
      r_wait      <= '0;
      r_be        <= '0;
      r_rdata     <= '0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_ce_n      <= STROBE_OFF;
      r_oe_n      <= STROBE_OFF;
      r_we_n      <= STROBE_OFF;
      {r_ub_n, r_lb_n} <= LANES_OFF;
      r_dq_oe     <= 1'b0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      for (int k = 0; k < HEX_WORDS; k++) r_hex[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      r_ready <= (w_state_nxt == ST_DONE);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_ce_n  <= w_ce_n;
      r_oe_n  <= w_oe_n;
      r_we_n  <= w_we_n;
      r_ub_n  <= w_ub_n;
      r_lb_n  <= w_lb_n;
      r_dq_oe <= w_dq_oe;

      if (w_accept) begin
        r_be <= cpu_be;
        if (w_is_io) begin
          // I/O completes at the accept edge; writes ignore byte enables.
          if (cpu_we) begin
            for (int k = 0; k < HEX_WORDS; k++) begin
              if (w_ofs == CPU_AW'(HEX_OFS0 + k)) r_hex[k] <= cpu_wdata;
            end
          end else begin
            r_rdata <= w_io_rdata;
          end
        end else begin
          r_sram_addr <= SRAM_AW'(cpu_addr);
          if (cpu_we) r_dq_out <= cpu_wdata;
        end
      end

      if ((r_state == ST_RD) && (w_state_nxt == ST_DONE)) r_rdata <= sram_dq_in;
    end
  end

  assign cpu_rdata   = r_rdata;
  assign cpu_ready   = r_ready;
  assign busy        = r_busy;
  assign sram_ce_n   = r_ce_n;
  assign sram_oe_n   = r_oe_n;
  assign sram_we_n   = r_we_n;
  assign sram_ub_n   = r_ub_n;
  assign sram_lb_n   = r_lb_n;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;

  for (genvar k = 0; k < HEX_WORDS; k++) begin : g_hex
    assign hex_out[16*k +: 16] = r_hex[k];
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// tb/tb_mem_io_ctrl.sv - directed self-checking bench for mem_io_ctrl
module tb_mem_io_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we;
  logic [1:0]  cpu_be;
  logic [15:0] cpu_addr, cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ready, busy;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [19:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe;
  logic [15:0] sw;
  logic [31:0] hex_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  mem_io_ctrl dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .busy(busy),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sw(sw), .hex_out(hex_out)
  );

  // Small async SRAM model: 16 words, byte-lane writes while we_n is low.
  logic [15:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 16'h0;
  always @(posedge Clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      if (!sram_lb_n) mem[sram_addr[3:0]][7:0]  <= sram_dq_out[7:0];
      if (!sram_ub_n) mem[sram_addr[3:0]][15:8] <= sram_dq_out[15:8];
    end
  end
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[3:0]] : 16'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Per-access observations, cycle n = n-th cycle after the accept edge.
  int          m_ce, m_oe, m_we, m_dqoe, m_busy, m_tog;
  int          m_we_first, m_we_last, m_rdy_cyc, m_rdy_cnt;
  logic [15:0] m_rdata;
  logic [19:0] m_addr;
  logic [1:0]  m_lanes;

  task automatic run_access(input logic we, input logic [1:0] be,
                            input logic [15:0] addr, input logic [15:0] wd,
                            input int window);
    m_ce = 0; m_oe = 0; m_we = 0; m_dqoe = 0; m_busy = 0; m_tog = 0;
    m_we_first = 0; m_we_last = 0; m_rdy_cyc = 0; m_rdy_cnt = 0;
    m_rdata = 'x; m_addr = 'x; m_lanes = 2'b11;
    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd;
    @(posedge Clk);
    #1 cpu_req = 1'b0;
    for (int n = 1; n <= window; n++) begin
      @(negedge Clk);
      if (n == 1) m_addr = sram_addr;
      if (!sram_ce_n) begin m_ce++; m_lanes = {sram_ub_n, sram_lb_n}; end
      if (!sram_oe_n) m_oe++;
      if (!sram_we_n) begin
        m_we++;
        if (m_we_first == 0) m_we_first = n;
        m_we_last = n;
      end
      if (sram_dq_oe) m_dqoe++;
      if (busy) m_busy++;
      if (!sram_ce_n || !sram_oe_n || !sram_we_n || !sram_ub_n || !sram_lb_n || sram_dq_oe)
        m_tog++;
      if (cpu_ready) begin m_rdy_cnt++; m_rdy_cyc = n; m_rdata = cpu_rdata; end
    end
  endtask

  int          rdy;
  int          last_rdy;
  logic [15:0] exp_d;

  initial begin
    Reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11;
    cpu_addr = 16'h0042; cpu_wdata = 16'h1234; sw = 16'h0;

    // 1: reset held with a pending request
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'h1f);
      check("rst_dq_oe", sram_dq_oe, 1'b0);
      check("rst_hex", hex_out, 32'h0);
      check("rst_ready", cpu_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
    end
    Reset = 1'b1; cpu_req = 1'b0;

    // 2: full-word SRAM write
    run_access(1'b1, 2'b11, 16'h0042, 16'h1234, 10);
    check("wr_addr", m_addr, 20'h00042);
    check("wr_ce_cycles", m_ce, 5);
    check("wr_we_cycles", m_we, 3);
    check("wr_we_first", m_we_first, 2);
    check("wr_we_last", m_we_last, 4);
    check("wr_dqoe_cycles", m_dqoe, 5);
    check("wr_oe_cycles", m_oe, 0);
    check("wr_lanes", m_lanes, 2'b00);
    check("wr_ready_cyc", m_rdy_cyc, 6);
    check("wr_ready_cnt", m_rdy_cnt, 1);
    check("wr_busy_cycles", m_busy, 6);

    // 3: SRAM read back, then lower-lane write and re-read
    run_access(1'b0, 2'b11, 16'h0042, 16'h0000, 8);
    check("rd_oe_cycles", m_oe, 3);
    check("rd_ce_cycles", m_ce, 3);
    check("rd_we_cycles", m_we, 0);
    check("rd_ready_cyc", m_rdy_cyc, 4);
    check("rd_ready_cnt", m_rdy_cnt, 1);
    check("rd_data", m_rdata, 16'h1234);

    run_access(1'b1, 2'b01, 16'h0042, 16'hABCD, 10);
    check("be01_lanes", m_lanes, 2'b10);
    check("be01_ready_cyc", m_rdy_cyc, 6);
    run_access(1'b0, 2'b11, 16'h0042, 16'h0000, 8);
    check("be01_readback", m_rdata, 16'h12CD);

    // 4: I/O accesses
    run_access(1'b1, 2'b00, 16'hFFF1, 16'hBEEF, 4);
    check("io_wr_ready_cyc", m_rdy_cyc, 1);
    check("io_wr_ready_cnt", m_rdy_cnt, 1);
    check("io_wr_toggles", m_tog, 0);
    check("io_wr_hex", hex_out, 32'hBEEF_0000);

    run_access(1'b0, 2'b11, 16'hFFF1, 16'h0000, 4);
    check("io_rd_ready_cyc", m_rdy_cyc, 1);
    check("io_rd_hex1", m_rdata, 16'hBEEF);
    check("io_rd_toggles", m_tog, 0);

    sw = 16'h00A5;
    repeat (3) @(negedge Clk);
    run_access(1'b0, 2'b11, 16'hFFF2, 16'h0000, 4);
    check("io_rd_sw", m_rdata, 16'h00A5);

    run_access(1'b0, 2'b11, 16'hFFF5, 16'h0000, 4);
    check("io_rd_unmapped", m_rdata, 16'h0000);
    check("io_rd_unmapped_cnt", m_rdy_cnt, 1);

    run_access(1'b1, 2'b11, 16'hFFF2, 16'h5555, 4);
    check("io_wr_sw_ignored", hex_out, 32'hBEEF_0000);
    run_access(1'b1, 2'b00, 16'hFFF0, 16'h1111, 4);
    check("io_wr_hex0", hex_out, 32'hBEEF_1111);

    // 5: reset in the second WR_PULSE cycle
    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11; cpu_addr = 16'h0043; cpu_wdata = 16'h7777;
    @(posedge Clk);
    #1 cpu_req = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    check("abort_in_pulse", sram_we_n, 1'b0);
    Reset = 1'b0;
    @(negedge Clk);
    check("abort_we_n", sram_we_n, 1'b1);
    check("abort_ce_n", sram_ce_n, 1'b1);
    check("abort_dq_oe", sram_dq_oe, 1'b0);
    check("abort_hex", hex_out, 32'h0);
    check("abort_busy", busy, 1'b0);
    Reset = 1'b1;
    rdy = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge Clk);
      if (cpu_ready) rdy++;
    end
    check("abort_no_ready", rdy, 0);

    // 6: request held high, I/O reads alternating between hex words
    run_access(1'b1, 2'b11, 16'hFFF0, 16'h1111, 3);
    run_access(1'b1, 2'b11, 16'hFFF1, 16'h2222, 3);
    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFFF0;
    exp_d = 16'h1111;
    rdy = 0; last_rdy = -1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge Clk);
      if (cpu_ready) begin
        rdy++;
        check("b2b_data", cpu_rdata, exp_d);
        if (last_rdy >= 0) check("b2b_spacing", n - last_rdy, 2);
        last_rdy = n;
        if (cpu_addr == 16'hFFF0) begin cpu_addr = 16'hFFF1; exp_d = 16'h2222; end
        else                      begin cpu_addr = 16'hFFF0; exp_d = 16'h1111; end
      end
    end
    check("b2b_count", rdy, 6);
    cpu_req = 1'b0;
    repeat (2) @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
